// File: rtl/pipe_ctrl.sv
// Stall/flush sequencer: combinational decode of state and requests, 0-cycle latency, it is the pipeline's hold source.
// Tracks EX/MEM multi-cycle waits plus a MEM watchdog; define PIPE_CTRL_PERF_EN to add performance counters.
module pipe_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_stall,
  input  logic             branch_taken_EX,
  input  logic             ex_start,
  input  logic             ex_done,
  input  logic             mem_req_MEM,
  input  logic             mem_ready,
  output logic             Stall_IF,
  output logic             Stall_ID,
  output logic             Stall_EX,
  output logic             Stall_MEM,
  output logic             Flush_ID,
  output logic             Flush_EX,
  output logic             Flush_MEM,
  output logic             Flush_WB,
  output logic             PC_Sel_EX,
  output logic [1:0]       ctrl_state,
`ifdef PIPE_CTRL_PERF_EN
  output logic [CNT_W-1:0] perf_stall_cycles,
  output logic [CNT_W-1:0] perf_flushes,
  output logic [CNT_W-1:0] perf_load_bubbles,
`endif
  output logic             mem_timeout_err
);

  localparam logic [1:0] ST_RUN      = 2'd0;
  localparam logic [1:0] ST_EX_WAIT  = 2'd1;
  localparam logic [1:0] ST_MEM_WAIT = 2'd2;

  localparam int WD_W = ($clog2(MEM_TIMEOUT + 1) > 5) ? $clog2(MEM_TIMEOUT + 1) : 5;
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(MEM_TIMEOUT);

  logic [1:0]      state_q, state_d;
  logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;
  logic            err_q, err_d;
  logic            do_run;
  logic            stall_if, stall_id, stall_ex, stall_mem;
  logic            flush_id, flush_ex, flush_mem, flush_wb, pc_sel;
`ifdef PIPE_CTRL_PERF_EN
  logic            load_bubble;
`endif

  always_comb begin
    state_d   = state_q;
    wd_cnt_d  = wd_cnt_q;
    err_d     = err_q;
    do_run    = 1'b0;
    stall_if  = 1'b0;
    stall_id  = 1'b0;
    stall_ex  = 1'b0;
    stall_mem = 1'b0;
    flush_id  = 1'b0;
    flush_ex  = 1'b0;
    flush_mem = 1'b0;
    flush_wb  = 1'b0;
    pc_sel    = 1'b0;
`ifdef PIPE_CTRL_PERF_EN
    load_bubble = 1'b0;
`endif
    case (state_q)
      ST_RUN: do_run = 1'b1;
      ST_EX_WAIT: begin
        if (ex_done) begin
          state_d = ST_RUN;
        end else begin
          {stall_if, stall_id, stall_ex, flush_mem} = 4'b1111;
        end
      end
      ST_MEM_WAIT: begin
        // Saturating count; the error latches once the limit is reached.
        wd_cnt_d = (wd_cnt_q == WD_MAX) ? WD_MAX : wd_cnt_q + 1'b1;
        if (wd_cnt_d == WD_MAX) err_d = 1'b1;
        if (mem_ready) begin
          state_d = ST_RUN;
          do_run  = 1'b1;
        end else begin
          {stall_if, stall_id, stall_ex, stall_mem, flush_wb} = 5'b11111;
        end
      end
      default: begin
        state_d = ST_RUN;
        do_run  = 1'b1;
      end
    endcase

    // In MEM_WAIT do_run only fires with mem_ready=1, so the MEM arm cannot re-trigger.
    if (do_run) begin
      if (mem_req_MEM && !mem_ready) begin
        {stall_if, stall_id, stall_ex, stall_mem, flush_wb} = 5'b11111;
        state_d  = ST_MEM_WAIT;
        wd_cnt_d = '0;
      end else if (ex_start) begin
        if (!ex_done) begin
          {stall_if, stall_id, stall_ex, flush_mem} = 4'b1111;
          state_d = ST_EX_WAIT;
        end
      end else if (branch_taken_EX) begin
        {pc_sel, flush_id, flush_ex} = 3'b111;
      end else if (load_stall) begin
        {stall_if, stall_id, flush_ex} = 3'b111;
`ifdef PIPE_CTRL_PERF_EN
        load_bubble = 1'b1;
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_RUN;
      wd_cnt_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      wd_cnt_q <= wd_cnt_d;
      err_q    <= err_d;
    end
  end

  // Gate with rst_n so nothing can pulse while reset is asserted.
  assign Stall_IF        = rst_n & stall_if;
  assign Stall_ID        = rst_n & stall_id;
  assign Stall_EX        = rst_n & stall_ex;
  assign Stall_MEM       = rst_n & stall_mem;
  assign Flush_ID        = rst_n & flush_id;
  assign Flush_EX        = rst_n & flush_ex;
  assign Flush_MEM       = rst_n & flush_mem;
  assign Flush_WB        = rst_n & flush_wb;
  assign PC_Sel_EX       = rst_n & pc_sel;
  assign ctrl_state      = state_q;
  assign mem_timeout_err = err_q;

`ifdef PIPE_CTRL_PERF_EN
  logic [CNT_W-1:0] perf_stall_q, perf_stall_d;
  logic [CNT_W-1:0] perf_flush_q, perf_flush_d;
  logic [CNT_W-1:0] perf_load_q,  perf_load_d;

  always_comb begin
    perf_stall_d = perf_stall_q + {{(CNT_W-1){1'b0}}, Stall_IF};
    perf_flush_d = perf_flush_q + {{(CNT_W-1){1'b0}}, PC_Sel_EX};
    perf_load_d  = perf_load_q  + {{(CNT_W-1){1'b0}}, load_bubble};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_stall_q <= '0;
      perf_flush_q <= '0;
      perf_load_q  <= '0;
    end else begin
      perf_stall_q <= perf_stall_d;
      perf_flush_q <= perf_flush_d;
      perf_load_q  <= perf_load_d;
    end
  end

  assign perf_stall_cycles = perf_stall_q;
  assign perf_flushes      = perf_flush_q;
  assign perf_load_bubbles = perf_load_q;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl (default build, MEM_TIMEOUT=4).
module tb_pipe_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       load_stall, branch_taken_EX, ex_start, ex_done, mem_req_MEM, mem_ready;
  logic       Stall_IF, Stall_ID, Stall_EX, Stall_MEM;
  logic       Flush_ID, Flush_EX, Flush_MEM, Flush_WB, PC_Sel_EX;
  logic [1:0] ctrl_state;
  logic       mem_timeout_err;
  logic [8:0] ctl;

  int tests = 0;
  int fails = 0;

  // Bit order: {SIF, SID, SEX, SMEM, FID, FEX, FMEM, FWB, PCSEL}
  localparam logic [8:0] C_NONE = 9'b000000000;
  localparam logic [8:0] C_LOAD = 9'b110001000;
  localparam logic [8:0] C_BR   = 9'b000011001;
  localparam logic [8:0] C_EX   = 9'b111000100;
  localparam logic [8:0] C_MEM  = 9'b111100010;

  pipe_ctrl #(.MEM_TIMEOUT(4), .CNT_W(32)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .load_stall      (load_stall),
    .branch_taken_EX (branch_taken_EX),
    .ex_start        (ex_start),
    .ex_done         (ex_done),
    .mem_req_MEM     (mem_req_MEM),
    .mem_ready       (mem_ready),
    .Stall_IF        (Stall_IF),
    .Stall_ID        (Stall_ID),
    .Stall_EX        (Stall_EX),
    .Stall_MEM       (Stall_MEM),
    .Flush_ID        (Flush_ID),
    .Flush_EX        (Flush_EX),
    .Flush_MEM       (Flush_MEM),
    .Flush_WB        (Flush_WB),
    .PC_Sel_EX       (PC_Sel_EX),
    .ctrl_state      (ctrl_state),
    .mem_timeout_err (mem_timeout_err)
  );

  assign ctl = {Stall_IF, Stall_ID, Stall_EX, Stall_MEM, Flush_ID, Flush_EX, Flush_MEM, Flush_WB, PC_Sel_EX};

  always #5 clk = ~clk;

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    load_stall = 0; branch_taken_EX = 0; ex_start = 0;
    ex_done = 0; mem_req_MEM = 0; mem_ready = 0;
  endtask

  task automatic test_reset();
    rst_n = 0;
    load_stall = 1; branch_taken_EX = 1; ex_start = 1;
    ex_done = 1; mem_req_MEM = 1; mem_ready = 1;
    @(negedge clk);
    tests++; if (ctl !== C_NONE) begin fails++; $display("FAIL reset_ctl got %b want %b", ctl, C_NONE); end
    tests++; if (ctrl_state !== 2'd0) begin fails++; $display("FAIL reset_state got %0d want 0", ctrl_state); end
    tests++; if (mem_timeout_err !== 1'b0) begin fails++; $display("FAIL reset_err got %b want 0", mem_timeout_err); end
    next_cycle();
    clear_inputs();
    rst_n = 1;
    @(negedge clk);
    tests++; if (ctl !== C_NONE) begin fails++; $display("FAIL idle_ctl got %b want %b", ctl, C_NONE); end
  endtask

  task automatic test_load_stall();
    next_cycle();
    load_stall = 1;
    @(negedge clk);
    tests++; if (ctl !== C_LOAD) begin fails++; $display("FAIL load_ctl got %b want %b", ctl, C_LOAD); end
    next_cycle();
    load_stall = 0;
    @(negedge clk);
    tests++; if (ctl !== C_NONE) begin fails++; $display("FAIL load_release got %b want %b", ctl, C_NONE); end
    tests++; if (ctrl_state !== 2'd0) begin fails++; $display("FAIL load_state got %0d want 0", ctrl_state); end
  endtask

  task automatic test_branch_load();
    next_cycle();
    branch_taken_EX = 1; load_stall = 1;
    @(negedge clk);
    tests++; if (ctl !== C_BR) begin fails++; $display("FAIL branch_ctl got %b want %b", ctl, C_BR); end
    next_cycle();
    clear_inputs();
    @(negedge clk);
    tests++; if (ctrl_state !== 2'd0) begin fails++; $display("FAIL branch_state got %0d want 0", ctrl_state); end
  endtask

  task automatic test_ex_wait();
    next_cycle();
    ex_start = 1;
    @(negedge clk);
    tests++; if (ctl !== C_EX) begin fails++; $display("FAIL ex_c0_ctl got %b want %b", ctl, C_EX); end
    next_cycle();
    ex_start = 0;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      tests++; if (ctl !== C_EX) begin fails++; $display("FAIL ex_c%0d_ctl got %b want %b", c, ctl, C_EX); end
      tests++; if (ctrl_state !== 2'd1) begin fails++; $display("FAIL ex_c%0d_state got %0d want 1", c, ctrl_state); end
      next_cycle();
    end
    ex_done = 1;
    @(negedge clk);
    tests++; if (ctl !== C_NONE) begin fails++; $display("FAIL ex_done_ctl got %b want %b", ctl, C_NONE); end
    next_cycle();
    ex_done = 0;
    @(negedge clk);
    tests++; if (ctrl_state !== 2'd0) begin fails++; $display("FAIL ex_exit_state got %0d want 0", ctrl_state); end
    // Single-cycle op: start and done together never stall.
    next_cycle();
    ex_start = 1; ex_done = 1;
    @(negedge clk);
    tests++; if (ctl !== C_NONE) begin fails++; $display("FAIL ex_1cyc_ctl got %b want %b", ctl, C_NONE); end
    next_cycle();
    clear_inputs();
    @(negedge clk);
    tests++; if (ctrl_state !== 2'd0) begin fails++; $display("FAIL ex_1cyc_state got %0d want 0", ctrl_state); end
  endtask

  task automatic test_mem_then_ex();
    next_cycle();
    mem_req_MEM = 1; mem_ready = 0; ex_start = 1;
    for (int c = 0; c <= 2; c++) begin
      @(negedge clk);
      tests++; if (ctl !== C_MEM) begin fails++; $display("FAIL mem_c%0d_ctl got %b want %b", c, ctl, C_MEM); end
      if (c > 0) begin
        tests++; if (ctrl_state !== 2'd2) begin fails++; $display("FAIL mem_c%0d_state got %0d want 2", c, ctrl_state); end
      end
      next_cycle();
    end
    mem_ready = 1;
    @(negedge clk);
    tests++; if (ctl !== C_EX) begin fails++; $display("FAIL mem_ready_ctl got %b want %b", ctl, C_EX); end
    next_cycle();
    mem_req_MEM = 0; mem_ready = 0; ex_start = 0;
    @(negedge clk);
    tests++; if (ctrl_state !== 2'd1) begin fails++; $display("FAIL mem_to_ex_state got %0d want 1", ctrl_state); end
    next_cycle();
    ex_done = 1;
    next_cycle();
    clear_inputs();
    @(negedge clk);
    tests++; if (ctrl_state !== 2'd0) begin fails++; $display("FAIL mem_ex_exit got %0d want 0", ctrl_state); end
  endtask

  task automatic test_timeout();
    next_cycle();
    mem_req_MEM = 1; mem_ready = 0;
    next_cycle();
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      tests++; if (mem_timeout_err !== (k >= 5)) begin fails++; $display("FAIL wd_k%0d got %b want %b", k, mem_timeout_err, (k >= 5)); end
      tests++; if (ctl !== C_MEM) begin fails++; $display("FAIL wd_k%0d_ctl got %b want %b", k, ctl, C_MEM); end
      next_cycle();
    end
    mem_ready = 1;
    next_cycle();
    clear_inputs();
    @(negedge clk);
    tests++; if (ctrl_state !== 2'd0) begin fails++; $display("FAIL wd_exit_state got %0d want 0", ctrl_state); end
    tests++; if (mem_timeout_err !== 1'b1) begin fails++; $display("FAIL wd_sticky got %b want 1", mem_timeout_err); end
    // Enter a fresh wait and abandon it with reset.
    next_cycle();
    mem_req_MEM = 1;
    next_cycle();
    next_cycle();
    rst_n = 0;
    #1;
    tests++; if (mem_timeout_err !== 1'b0) begin fails++; $display("FAIL rst_mid_err got %b want 0", mem_timeout_err); end
    tests++; if (ctrl_state !== 2'd0) begin fails++; $display("FAIL rst_mid_state got %0d want 0", ctrl_state); end
    tests++; if (ctl !== C_NONE) begin fails++; $display("FAIL rst_mid_ctl got %b want %b", ctl, C_NONE); end
    @(negedge clk);
    clear_inputs();
    rst_n = 1;
    next_cycle();
    @(negedge clk);
    tests++; if (ctrl_state !== 2'd0) begin fails++; $display("FAIL rst_after_state got %0d want 0", ctrl_state); end
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout got running want finished");
    $fatal(1, "timeout");
  end

  initial begin
    clear_inputs();
    rst_n = 0;
    test_reset();
    test_load_stall();
    test_branch_load();
    test_ex_wait();
    test_mem_then_ex();
    test_timeout();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
